// File: rtl/cpu_pkg.sv
// Shared datapath width constants for the CPU.
// Parent modules use these to override the sign_ext widths.
package cpu_pkg;

    localparam int IMM_WIDTH  = 16;
    localparam int DATA_WIDTH = 32;

endpackage

// File: rtl/sign_ext_ext_core.sv
// ext_core: combinational widener from IN_SIZE to OUT_SIZE bits.
// When zext is high the upper bits are zero-filled; otherwise they copy the input MSB.
module ext_core
    import cpu_pkg::*;
#(
    parameter int IN_SIZE  = IMM_WIDTH,
    parameter int OUT_SIZE = DATA_WIDTH
) (
    input  logic [IN_SIZE-1:0]  in,
    input  logic                zext,
    output logic [OUT_SIZE-1:0] result
);

    // Equal widths get a plain pass-through so no zero-width replication is built.
    if (OUT_SIZE > IN_SIZE) begin : g_widen
        logic fill;
        assign fill   = zext ? 1'b0 : in[IN_SIZE-1];
        assign result = {{(OUT_SIZE-IN_SIZE){fill}}, in};
    end else begin : g_pass
        logic unused_zext;
        assign unused_zext = zext;
        assign result      = in;
    end

endmodule

// File: rtl/sign_ext.sv
// sign_ext: widens an immediate/offset field to the datapath width.
// 'out' is always a combinational sign-extension of 'in'.
// Build option SIGN_EXT_REG_OUT_EN: when defined, out_q/out_valid come from a
// one-cycle register stage with synchronous active-high reset; when undefined,
// out_q/out_valid are combinational and clk/rst are unused.
module sign_ext
    import cpu_pkg::*;
#(
    parameter int IN_SIZE  = IMM_WIDTH,
    parameter int OUT_SIZE = DATA_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_SIZE-1:0]  in,
    input  logic                in_valid,
    input  logic                zext,
    output logic [OUT_SIZE-1:0] out,
    output logic [OUT_SIZE-1:0] out_q,
    output logic                out_valid
);

    if (IN_SIZE < 1) begin : g_bad_in_size
        $error("sign_ext: IN_SIZE must be at least 1");
    end
    if (OUT_SIZE < IN_SIZE) begin : g_bad_out_size
        $error("sign_ext: OUT_SIZE must not be smaller than IN_SIZE");
    end

    logic [OUT_SIZE-1:0] ext_sel;

    ext_core #(
        .IN_SIZE (IN_SIZE),
        .OUT_SIZE(OUT_SIZE)
    ) u_ext_sign (
        .in    (in),
        .zext  (1'b0),
        .result(out)
    );

    ext_core #(
        .IN_SIZE (IN_SIZE),
        .OUT_SIZE(OUT_SIZE)
    ) u_ext_sel (
        .in    (in),
        .zext  (zext),
        .result(ext_sel)
    );

`ifdef SIGN_EXT_REG_OUT_EN
    logic [OUT_SIZE-1:0] out_q_r;
    logic                out_valid_r;

    // Capture the selected extension on valid input; reset wins over a valid input.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q_r     <= '0;
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            out_q_r     <= ext_sel;
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_q     = out_q_r;
    assign out_valid = out_valid_r;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign out_q     = ext_sel;
    assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_sign_ext.sv
// Directed bench for sign_ext covering 2->4, 16->32 and 8->8 instances.
// Expectations for out_q/out_valid follow whichever build SIGN_EXT_REG_OUT_EN selects.
module tb_sign_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        zext;

    logic [1:0]  in4;
    logic [3:0]  out4, out_q4;
    logic        out_valid4;

    logic [15:0] in32;
    logic [31:0] out32, out_q32;
    logic        out_valid32;

    logic [7:0]  in8;
    logic [7:0]  out8, out_q8;
    logic        out_valid8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sign_ext #(.IN_SIZE(2), .OUT_SIZE(4)) dut4 (
        .clk(clk), .rst(1'b0), .in(in4), .in_valid(1'b0), .zext(1'b0),
        .out(out4), .out_q(out_q4), .out_valid(out_valid4)
    );

    sign_ext #(.IN_SIZE(16), .OUT_SIZE(32)) dut32 (
        .clk(clk), .rst(rst), .in(in32), .in_valid(in_valid), .zext(zext),
        .out(out32), .out_q(out_q32), .out_valid(out_valid32)
    );

    sign_ext #(.IN_SIZE(8), .OUT_SIZE(8)) dut8 (
        .clk(clk), .rst(rst), .in(in8), .in_valid(in_valid), .zext(zext),
        .out(out8), .out_q(out_q8), .out_valid(out_valid8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] s_in  [3];
    logic [31:0] s_exp [3];

    initial begin
        rst = 1'b1; in_valid = 1'b0; zext = 1'b0;
        in4 = 2'b00; in32 = 16'h0; in8 = 8'h0;
        s_in[0] = 16'h0001; s_exp[0] = 32'h00000001;
        s_in[1] = 16'hFFFF; s_exp[1] = 32'hFFFFFFFF;
        s_in[2] = 16'h1234; s_exp[2] = 32'h00001234;

        // 2 -> 4 combinational path
        @(negedge clk);
        in4 = 2'b01; #1;
        chk("w4_pos", 64'(out4), 64'h1);
        in4 = 2'b10; #1;
        chk("w4_neg", 64'(out4), 64'hE);

        // reset held two cycles with valid input present
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; zext = 1'b0; in32 = 16'h7FFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out", 64'(out32), 64'h00007FFF);
`ifdef SIGN_EXT_REG_OUT_EN
            chk("rst_q", 64'(out_q32), 64'h0);
            chk("rst_v", 64'(out_valid32), 64'h0);
`else
            chk("rst_q", 64'(out_q32), 64'h00007FFF);
            chk("rst_v", 64'(out_valid32), 64'h1);
`endif
        end

        // sign extension of negative value
        @(negedge clk);
        rst = 1'b0; in32 = 16'h8000; zext = 1'b0; in_valid = 1'b1;
        #1;
        chk("sx_out", 64'(out32), 64'hFFFF8000);
        tick();
        chk("sx_q", 64'(out_q32), 64'hFFFF8000);
        chk("sx_v", 64'(out_valid32), 64'h1);

        // zero extension only affects out_q
        @(negedge clk);
        zext = 1'b1;
        #1;
        chk("zx_out", 64'(out32), 64'hFFFF8000);
        tick();
        chk("zx_q", 64'(out_q32), 64'h00008000);
        chk("zx_v", 64'(out_valid32), 64'h1);

        // back-to-back stream
        zext = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in32 = s_in[i]; in_valid = 1'b1;
            tick();
            chk($sformatf("strm_q%0d", i), 64'(out_q32), 64'(s_exp[i]));
            chk($sformatf("strm_v%0d", i), 64'(out_valid32), 64'h1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tick();
        chk("idle_v", 64'(out_valid32), 64'h0);
        chk("idle_q", 64'(out_q32), 64'h00001234);

        // reset mid-stream discards the pending capture
        @(negedge clk);
        in32 = 16'h5555; in_valid = 1'b1; rst = 1'b1;
        tick();
`ifdef SIGN_EXT_REG_OUT_EN
        chk("mid_rst_q", 64'(out_q32), 64'h0);
        chk("mid_rst_v", 64'(out_valid32), 64'h0);
`else
        chk("mid_rst_q", 64'(out_q32), 64'h00005555);
        chk("mid_rst_v", 64'(out_valid32), 64'h1);
`endif
        chk("mid_rst_out", 64'(out32), 64'h00005555);

        // equal widths: pass-through regardless of zext
        @(negedge clk);
        rst = 1'b0; in8 = 8'h80; zext = 1'b0; in_valid = 1'b1;
        tick();
        chk("w8_out", 64'(out8), 64'h80);
        chk("w8_q_sx", 64'(out_q8), 64'h80);
        @(negedge clk);
        zext = 1'b1;
        tick();
        chk("w8_q_zx", 64'(out_q8), 64'h80);
        chk("w8_v", 64'(out_valid8), 64'h1);

`ifndef SIGN_EXT_REG_OUT_EN
        // combinational build: out_valid tracks in_valid immediately
        @(negedge clk);
        in_valid = 1'b0; #1;
        chk("comb_v0", 64'(out_valid32), 64'h0);
        in_valid = 1'b1; in32 = 16'hC001; zext = 1'b1; #1;
        chk("comb_v1", 64'(out_valid32), 64'h1);
        chk("comb_q", 64'(out_q32), 64'h0000C001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sign_ext.md
# sign_ext

Parameterised sign-extension block for the CPU datapath. It widens an IN_SIZE-bit immediate or offset field to the OUT_SIZE-bit datapath width. It provides a purely combinational sign-extended result for single-cycle use, plus a one-cycle registered result with optional zero-extension for pipelined use. It sits between instruction decode and the ALU operand mux.

## Interface
Parameters:
- IN_SIZE, default 16: width of the input field; must be ≥1.
- OUT_SIZE, default 32: width of the extended result; must be ≥ IN_SIZE. OUT_SIZE < IN_SIZE is an elaboration-time error.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  synchronous, active-high reset.
- in  input  IN_SIZE  field to extend.
- in_valid  input  1  qualifies `in` for the registered path.
- zext  input  1  registered path only: 1 = zero-extend, 0 = sign-extend.
- out  output  OUT_SIZE  combinational sign-extension of `in`.
- out_q  output  OUT_SIZE  registered extension result.
- out_valid  output  1  out_q holds a result captured from a valid input.

## Operation
- `out` is the sign-extended value of `in`:
  - out[IN_SIZE-1:0] = in.
  - out[OUT_SIZE-1:IN_SIZE] = replicated in[IN_SIZE-1].
- `out` depends only on `in`. It is independent of clk, rst, zext and in_valid, so it is correct even when those pins are left unconnected.
- When OUT_SIZE == IN_SIZE, out = in (pass-through, no replicated bits).
- Registered path, on a rising clk edge:
  - If rst: out_q ← 0 and out_valid ← 0.
  - Else if in_valid: out_q ← (zext ? zero-extend(in) : sign-extend(in)) and out_valid ← 1.
  - Else: out_q holds its value and out_valid ← 0.
- Zero-extension fills the upper OUT_SIZE-IN_SIZE bits with 0.
- rst has priority over in_valid when both are asserted in the same cycle.
- No internal state exists beyond out_q and out_valid.

## Timing
- `out`: zero-cycle combinational latency.
- out_q / out_valid:
  - One cycle of latency after the edge that samples in_valid=1.
  - Back-to-back valid inputs produce back-to-back results, one per cycle, with no bubbles.
- Reset values: out_q = 0 and out_valid = 0 from the first edge with rst=1. Both remain 0 while rst is held.
- Asserting rst mid-stream discards the pending result on that edge.
- The value on `out` is unaffected by reset.

## Configuration
- SIGN_EXT_REG_OUT_EN defined: the registered path is built exactly as described above.
- SIGN_EXT_REG_OUT_EN undefined: the registered path is removed and clk/rst are unused.
  - out_q = (zext ? zero-extend(in) : sign-extend(in)), combinational.
  - out_valid = in_valid, combinational.
- Ports are identical in both builds, and `out` behaves the same in both.

## Structure
- Shared package `cpu_pkg`: the default widths as constants, IMM_WIDTH = 16 and DATA_WIDTH = 32. Parent modules use these to override IN_SIZE / OUT_SIZE.
- One sub-module is natural: `ext_core`, the combinational extender (in, zext → result).
  - It is instantiated twice: once with zext tied to 0 for `out`, and once for the registered or combinational out_q path.
- Width legality is checked with a generate-time error.

## Test plan
- IN_SIZE=2, OUT_SIZE=4; in=2'b01 with zext and in_valid unconnected -> out=4'b0001. Then in=2'b10 -> out=4'b1110. Both respond within the same time step.
- IN_SIZE=16, OUT_SIZE=32:
  - in=16'h8000, zext=0, in_valid=1 -> out=32'hFFFF8000 immediately, and out_q=32'hFFFF8000 with out_valid=1 one cycle later.
  - Same input with zext=1 -> out=32'hFFFF8000 and out_q=32'h00008000.
- Reset: hold rst=1 for 2 cycles with in_valid=1 and in=16'h7FFF -> out_q=0 and out_valid=0 throughout, while out=32'h00007FFF.
- Streaming: in=16'h0001, 16'hFFFF, 16'h1234 on consecutive cycles with in_valid=1, then in_valid=0 -> out_q = 32'h00000001, 32'hFFFFFFFF, 32'h00001234 on consecutive cycles, then out_valid=0 with out_q held at 32'h00001234.
- IN_SIZE=OUT_SIZE=8; in=8'h80 -> out=8'h80 and out_q=8'h80 regardless of zext. Build without SIGN_EXT_REG_OUT_EN -> out_q equals the extension combinationally and out_valid tracks in_valid.
